// File: rtl/note_sequencer.sv
// note_sequencer: walks a song table held in a synchronous ROM and drives one note_player voice.
// Each 16-bit entry is decoded into pitch/duration/instrument plus an end flag. The block issues
// a single-cycle load, then waits for the player's done before fetching the next entry.
//
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_start, i_stop   begin playback (only while idle) / abort playback (highest priority)
//   i_loop            on an end-flagged note: 1 = continue at LOOP_ADDR, 0 = stop
//   i_player_done     note_player done, level or pulse
//   o_rom_addr        song ROM address; i_rom_data is valid one cycle later
//   o_load            single-cycle load strobe to note_player
//   o_pitch, o_duration, o_instrument   decoded fields, held after the load
//   o_busy            high whenever the sequencer is not idle
//   o_song_end        one-cycle pulse when playback ends naturally
module note_sequencer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LOOP_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_loop,
  input  logic                  i_player_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [15:0]           i_rom_data,
  output logic                  o_load,
  output logic [5:0]            o_pitch,
  output logic [4:0]            o_duration,
  output logic [3:0]            o_instrument,
  output logic                  o_busy,
  output logic                  o_song_end
);

  localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LoopAddr  = ADDR_WIDTH'(LOOP_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StLoad,
    StArm,
    StPlay
  } state_e;

  state_e state_q;
  logic   end_flag_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      end_flag_q   <= 1'b0;
      o_rom_addr   <= StartAddr;
      o_load       <= 1'b0;
      o_pitch      <= '0;
      o_duration   <= '0;
      o_instrument <= '0;
      o_busy       <= 1'b0;
      o_song_end   <= 1'b0;
    end else begin
      // Strobes default low; only DECODE and the natural end raise them.
      o_load     <= 1'b0;
      o_song_end <= 1'b0;
      if (i_stop) begin
        state_q <= StIdle;
        o_busy  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (i_start) begin
              o_rom_addr <= StartAddr;
              o_busy     <= 1'b1;
              state_q    <= StFetch;
            end
          end
          StFetch: state_q <= StDecode;
          StDecode: begin
            o_pitch      <= i_rom_data[15:10];
            o_duration   <= i_rom_data[9:5];
            o_instrument <= i_rom_data[4:1];
            end_flag_q   <= i_rom_data[0];
            o_load       <= 1'b1;
            state_q      <= StLoad;
          end
          StLoad: state_q <= StArm;
          // Done is ignored here so a level still held from the previous note is not taken
          // as completion of the note just loaded.
          StArm: state_q <= StPlay;
          StPlay: begin
            if (i_player_done) begin
              if (!end_flag_q) begin
                o_rom_addr <= o_rom_addr + 1'b1;
                state_q    <= StFetch;
              end else if (i_loop) begin
                o_rom_addr <= LoopAddr;
                state_q    <= StFetch;
              end else begin
                o_song_end <= 1'b1;
                o_busy     <= 1'b0;
                state_q    <= StIdle;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
